// File: rtl/tlb_multiport.sv
// Fully associative multi-port TLB: registered parallel searches, 4 KB / 2 MB pages,
// round-robin TLBFILL victim pointer and a multi-cycle INVTLB sweep engine.
module tlb_multiport #(
    parameter  int TLBNUM        = 16,
    parameter  int NSRCH         = 2,
    parameter  int PPNW          = 20,
    parameter  int INV_PER_CYCLE = 4,
    localparam int IDXW          = $clog2(TLBNUM),
    localparam int PTW           = PPNW + 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NSRCH-1:0]      s_req,
    input  logic [NSRCH*20-1:0]   s_va,
    input  logic [NSRCH*10-1:0]   s_asid,
    output logic [NSRCH-1:0]      s_valid,
    output logic [NSRCH-1:0]      s_hit,
    output logic [NSRCH*IDXW-1:0] s_index,
    output logic [NSRCH*6-1:0]    s_ps,
    output logic [NSRCH*PTW-1:0]  s_phytran,
    input  logic [IDXW-1:0]       r_index,
    output logic                  r_e,
    output logic                  r_g,
    output logic [9:0]            r_asid,
    output logic [18:0]           r_vppn,
    output logic [5:0]            r_ps,
    output logic [PTW-1:0]        r_phytran0,
    output logic [PTW-1:0]        r_phytran1,
    input  logic                  we,
    input  logic                  fill,
    input  logic [IDXW-1:0]       w_index,
    input  logic                  w_e,
    input  logic                  w_g,
    input  logic [9:0]            w_asid,
    input  logic [18:0]           w_vppn,
    input  logic [5:0]            w_ps,
    input  logic [PTW-1:0]        w_phytran0,
    input  logic [PTW-1:0]        w_phytran1,
    output logic [IDXW-1:0]       fill_index,
    input  logic                  inv_req,
    input  logic [2:0]            inv_op,
    input  logic [9:0]            inv_asid,
    input  logic [19:0]           inv_va,
    output logic                  inv_busy,
    output logic                  inv_done,
    output logic                  inv_bad_op
);

    localparam int K    = TLBNUM / INV_PER_CYCLE;
    localparam int GRPW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {INV_IDLE, INV_SWEEP, INV_DONE, INV_BAD} inv_state_e;

    logic [TLBNUM-1:0] e_q, e_d, g_q;
    logic [9:0]        asid_q [TLBNUM];
    logic [18:0]       vppn_q [TLBNUM];
    logic [5:0]        ps_q   [TLBNUM];
    logic [PTW-1:0]    pt0_q  [TLBNUM];
    logic [PTW-1:0]    pt1_q  [TLBNUM];

    logic [IDXW-1:0]   fill_q, fill_d;
    logic [TLBNUM-1:0] wr_sel, inv_clr;

    inv_state_e        st_q, st_d;
    logic [GRPW-1:0]   grp_q, grp_d;
    logic [2:0]        op_q, op_d;
    logic [9:0]        iasid_q, iasid_d;
    logic [19:0]       iva_q, iva_d;

    logic [NSRCH-1:0]      valid_q, hit_c, hit_q;
    logic [NSRCH*IDXW-1:0] idx_c, idx_q;
    logic [NSRCH*6-1:0]    ps_c, psr_q;
    logic [NSRCH*PTW-1:0]  pt_c, pt_q;

    // Page-size aware VPN compare; unsupported page sizes never match.
    function automatic logic va_hit(input logic [18:0] vppn, input logic [5:0] ps,
                                    input logic [19:0] va);
        if (ps == 6'd12) return vppn == va[19:1];
        if (ps == 6'd21) return vppn[18:9] == va[19:10];
        return 1'b0;
    endfunction

    function automatic logic va_odd(input logic [5:0] ps, input logic [19:0] va);
        return (ps == 6'd21) ? va[9] : va[0];
    endfunction

    function automatic logic inv_pred(input logic [2:0] op, input logic g,
                                      input logic am, input logic vm);
        case (op)
            3'd0, 3'd1: return 1'b1;
            3'd2:       return g;
            3'd3:       return !g;
            3'd4:       return !g && am;
            3'd5:       return !g && am && vm;
            3'd6:       return (g || am) && vm;
            default:    return 1'b0;
        endcase
    endfunction

    // Search: every port scans all entries; descending scan leaves the lowest hit.
    always_comb begin
        hit_c = '0;
        idx_c = '0;
        ps_c  = '0;
        pt_c  = '0;
        for (int k = 0; k < NSRCH; k++) begin
            for (int i = TLBNUM - 1; i >= 0; i--) begin
                if (e_q[i] && (g_q[i] || asid_q[i] == s_asid[k*10 +: 10]) &&
                    va_hit(vppn_q[i], ps_q[i], s_va[k*20 +: 20])) begin
                    hit_c[k]              = 1'b1;
                    idx_c[k*IDXW +: IDXW] = IDXW'(i);
                    ps_c[k*6 +: 6]        = ps_q[i];
                    pt_c[k*PTW +: PTW]    = va_odd(ps_q[i], s_va[k*20 +: 20]) ? pt1_q[i] : pt0_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            hit_q   <= '0;
            idx_q   <= '0;
            psr_q   <= '0;
            pt_q    <= '0;
        end else begin
            valid_q <= s_req;
            hit_q   <= hit_c;
            idx_q   <= idx_c;
            psr_q   <= ps_c;
            pt_q    <= pt_c;
        end
    end

    assign s_valid   = valid_q;
    assign s_hit     = hit_q;
    assign s_index   = idx_q;
    assign s_ps      = psr_q;
    assign s_phytran = pt_q;

    assign r_e        = e_q[r_index];
    assign r_g        = g_q[r_index];
    assign r_asid     = asid_q[r_index];
    assign r_vppn     = vppn_q[r_index];
    assign r_ps       = ps_q[r_index];
    assign r_phytran0 = pt0_q[r_index];
    assign r_phytran1 = pt1_q[r_index];

    // Write target: TLBWR has priority and a colliding fill is dropped.
    always_comb begin
        wr_sel = '0;
        fill_d = fill_q;
        if (we) begin
            wr_sel[w_index] = 1'b1;
        end else if (fill) begin
            wr_sel[fill_q] = 1'b1;
            fill_d         = fill_q + IDXW'(1);
        end
    end

    always_comb begin
        inv_clr = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            if (st_q == INV_SWEEP && (i / INV_PER_CYCLE) == int'(grp_q)) begin
                inv_clr[i] = inv_pred(op_q, g_q[i], asid_q[i] == iasid_q,
                                      va_hit(vppn_q[i], ps_q[i], iva_q));
            end
        end
    end

    // A write landing on an entry being swept overrides the clear.
    always_comb begin
        for (int i = 0; i < TLBNUM; i++) begin
            e_d[i] = wr_sel[i] ? w_e : (e_q[i] && !inv_clr[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q    <= '0;
            fill_q <= '0;
        end else begin
            e_q    <= e_d;
            fill_q <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < TLBNUM; i++) begin
            if (wr_sel[i]) begin
                g_q[i]    <= w_g;
                asid_q[i] <= w_asid;
                vppn_q[i] <= w_vppn;
                ps_q[i]   <= w_ps;
                pt0_q[i]  <= w_phytran0;
                pt1_q[i]  <= w_phytran1;
            end
        end
    end

    assign fill_index = fill_q;

    // INVTLB engine: the one-cycle done states behave as idle for new requests.
    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q  <= INV_IDLE;
            grp_q <= '0;
        end else begin
            st_q  <= st_d;
            grp_q <= grp_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q    <= op_d;
        iasid_q <= iasid_d;
        iva_q   <= iva_d;
    end

    always_comb begin
        st_d    = st_q;
        grp_d   = grp_q;
        op_d    = op_q;
        iasid_d = iasid_q;
        iva_d   = iva_q;
        case (st_q)
            INV_SWEEP: begin
                grp_d = grp_q + GRPW'(1);
                if (grp_q == GRPW'(K - 1)) begin
                    st_d  = INV_DONE;
                    grp_d = '0;
                end
            end
            default: begin
                st_d = INV_IDLE;
                if (inv_req) begin
                    op_d    = inv_op;
                    iasid_d = inv_asid;
                    iva_d   = inv_va;
                    grp_d   = '0;
                    st_d    = (inv_op > 3'd6) ? INV_BAD : INV_SWEEP;
                end
            end
        endcase
    end

    always_comb begin
        inv_busy   = 1'b0;
        inv_done   = 1'b0;
        inv_bad_op = 1'b0;
        case (st_q)
            INV_SWEEP: inv_busy = 1'b1;
            INV_DONE:  inv_done = 1'b1;
            INV_BAD: begin
                inv_done   = 1'b1;
                inv_bad_op = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tlb_multiport.sv
// Directed and randomized checks of tlb_multiport against a table-level reference model.
module tb_tlb_multiport;
    localparam int TLBNUM = 16;
    localparam int IPC    = 4;
    localparam int K      = TLBNUM / IPC;

    typedef struct packed {
        bit        e;
        bit        g;
        bit [9:0]  asid;
        bit [18:0] vppn;
        bit [5:0]  ps;
        bit [25:0] p0;
        bit [25:0] p1;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  s_req, s_valid, s_hit;
    logic [39:0] s_va;
    logic [19:0] s_asid;
    logic [7:0]  s_index;
    logic [11:0] s_ps;
    logic [51:0] s_phytran;
    logic [3:0]  r_index, w_index, fill_index;
    logic        r_e, r_g, we, fill, w_e, w_g;
    logic [9:0]  r_asid, w_asid, inv_asid;
    logic [18:0] r_vppn, w_vppn;
    logic [5:0]  r_ps, w_ps;
    logic [25:0] r_phytran0, r_phytran1, w_phytran0, w_phytran1;
    logic        inv_req, inv_busy, inv_done, inv_bad_op;
    logic [2:0]  inv_op;
    logic [19:0] inv_va;

    int checks = 0;
    int errors = 0;

    ent_t m_tab [TLBNUM];
    int   m_fill;
    bit [18:0] vpool [4] = '{19'h00100, 19'h00101, 19'h1F200, 19'h0AB00};

    tlb_multiport dut (
        .clk(clk), .reset(reset),
        .s_req(s_req), .s_va(s_va), .s_asid(s_asid),
        .s_valid(s_valid), .s_hit(s_hit), .s_index(s_index), .s_ps(s_ps), .s_phytran(s_phytran),
        .r_index(r_index), .r_e(r_e), .r_g(r_g), .r_asid(r_asid), .r_vppn(r_vppn), .r_ps(r_ps),
        .r_phytran0(r_phytran0), .r_phytran1(r_phytran1),
        .we(we), .fill(fill), .w_index(w_index), .w_e(w_e), .w_g(w_g), .w_asid(w_asid),
        .w_vppn(w_vppn), .w_ps(w_ps), .w_phytran0(w_phytran0), .w_phytran1(w_phytran1),
        .fill_index(fill_index),
        .inv_req(inv_req), .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
        .inv_busy(inv_busy), .inv_done(inv_done), .inv_bad_op(inv_bad_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_vam(input int i, input bit [19:0] va);
        if (m_tab[i].ps == 6'd12) return int'(m_tab[i].vppn) == int'(va) / 2;
        if (m_tab[i].ps == 6'd21) return int'(m_tab[i].vppn) / 512 == int'(va) / 1024;
        return 1'b0;
    endfunction

    function automatic void m_search(input bit [19:0] va, input bit [9:0] asid, output bit hit,
                                     output int idx, output bit [5:0] ps, output bit [25:0] pt);
        int odd;
        hit = 0; idx = 0; ps = 0; pt = 0;
        for (int i = 0; i < TLBNUM; i++) begin
            if (!hit && m_tab[i].e && (m_tab[i].g || m_tab[i].asid == asid) && m_vam(i, va)) begin
                hit = 1;
                idx = i;
                ps  = m_tab[i].ps;
                odd = (m_tab[i].ps == 6'd21) ? (int'(va) / 512) % 2 : int'(va) % 2;
                pt  = (odd == 1) ? m_tab[i].p1 : m_tab[i].p0;
            end
        end
    endfunction

    function automatic bit m_pred(input int i, input int op, input bit [9:0] asid, input bit [19:0] va);
        bit am = (m_tab[i].asid == asid);
        bit vm = m_vam(i, va);
        bit g  = m_tab[i].g;
        case (op)
            0, 1:    return 1;
            2:       return g;
            3:       return !g;
            4:       return !g && am;
            5:       return !g && am && vm;
            6:       return (g || am) && vm;
            default: return 0;
        endcase
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < TLBNUM; i++) m_tab[i].e = 0;
        m_fill = 0;
    endfunction

    function automatic ent_t mk(input bit e, input bit g, input bit [9:0] asid, input bit [18:0] vppn,
                                input bit [5:0] ps, input bit [19:0] ppn0, input bit [19:0] ppn1);
        ent_t x;
        x.e = e; x.g = g; x.asid = asid; x.vppn = vppn; x.ps = ps;
        x.p0 = {ppn0, 6'h13};
        x.p1 = {ppn1, 6'h2C};
        return x;
    endfunction

    function automatic ent_t rnd_ent();
        ent_t x;
        int   s = $urandom_range(0, 3);
        x.e    = ($urandom_range(0, 7) != 0);
        x.g    = $urandom_range(0, 1);
        x.asid = 10'($urandom_range(1, 3));
        x.vppn = vpool[$urandom_range(0, 3)] + 19'($urandom_range(0, 1));
        x.ps   = (s == 2) ? 6'd21 : ((s == 3) ? 6'd13 : 6'd12);
        x.p0   = 26'($urandom);
        x.p1   = 26'($urandom);
        return x;
    endfunction

    // A VA that the page of entry i would translate (for 4 KB / 2 MB pages).
    function automatic bit [19:0] va_of(input int i);
        if (m_tab[i].ps == 6'd21) return {m_tab[i].vppn[18:9], 10'($urandom)};
        return {m_tab[i].vppn, 1'($urandom)};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_w(input ent_t x);
        w_e = x.e; w_g = x.g; w_asid = x.asid; w_vppn = x.vppn; w_ps = x.ps;
        w_phytran0 = x.p0; w_phytran1 = x.p1;
    endtask

    task automatic wr(input int idx, input ent_t x);
        drive_w(x);
        w_index = 4'(idx);
        we = 1;
        step();
        we = 0;
        m_tab[idx] = x;
    endtask

    task automatic do_fill(input ent_t x);
        drive_w(x);
        fill = 1;
        step();
        fill = 0;
        m_tab[m_fill] = x;
        m_fill = (m_fill + 1) % TLBNUM;
    endtask

    task automatic chk_port(input int k, input bit h, input int ix, input bit [5:0] ps,
                            input bit [25:0] pt, input bit req, input string tag);
        chk({tag, "_valid"}, s_valid[k], req);
        chk({tag, "_hit"}, s_hit[k], h);
        chk({tag, "_index"}, s_index[k*4 +: 4], ix);
        chk({tag, "_ps"}, s_ps[k*6 +: 6], ps);
        chk({tag, "_phytran"}, s_phytran[k*26 +: 26], pt);
    endtask

    task automatic srch2(input bit [19:0] va0, input bit [9:0] a0, input bit [19:0] va1,
                         input bit [9:0] a1, input string tag);
        bit h0, h1; int i0, i1; bit [5:0] p0, p1; bit [25:0] t0, t1;
        m_search(va0, a0, h0, i0, p0, t0);
        m_search(va1, a1, h1, i1, p1, t1);
        s_req = 2'b11; s_va = {va1, va0}; s_asid = {a1, a0};
        step();
        s_req = 2'b00;
        chk_port(0, h0, i0, p0, t0, 1, {tag, "_p0"});
        chk_port(1, h1, i1, p1, t1, 1, {tag, "_p1"});
    endtask

    task automatic chk_all_e(input string tag);
        for (int i = 0; i < TLBNUM; i++) begin
            r_index = 4'(i);
            #1;
            chk($sformatf("%s_e%0d", tag, i), r_e, m_tab[i].e);
        end
    endtask

    task automatic do_reset();
        reset = 0;
        step();
        reset = 1;
        m_reset();
    endtask

    // Full INVTLB: checks the busy window, per-group clearing and the done pulse.
    task automatic inv_run(input int op, input bit [9:0] asid, input bit [19:0] va, input string tag);
        inv_req = 1; inv_op = 3'(op); inv_asid = asid; inv_va = va;
        step();
        inv_req = 0;
        if (op > 6) begin
            chk({tag, "_bad_busy"}, inv_busy, 0);
            chk({tag, "_bad_done"}, inv_done, 1);
            chk({tag, "_bad_flag"}, inv_bad_op, 1);
            step();
            chk({tag, "_bad_done2"}, inv_done, 0);
            chk({tag, "_bad_busy2"}, inv_busy, 0);
            return;
        end
        for (int c = 0; c < K; c++) begin
            chk($sformatf("%s_busy%0d", tag, c), inv_busy, 1);
            chk($sformatf("%s_ndone%0d", tag, c), inv_done, 0);
            step();
            for (int j = 0; j < IPC; j++)
                if (m_pred(c*IPC + j, op, asid, va)) m_tab[c*IPC + j].e = 0;
            r_index = 4'(c*IPC + $urandom_range(0, IPC-1));
            #1;
            chk($sformatf("%s_grp%0d", tag, c), r_e, m_tab[r_index].e);
        end
        chk({tag, "_end_busy"}, inv_busy, 0);
        chk({tag, "_done"}, inv_done, 1);
        chk({tag, "_nbad"}, inv_bad_op, 0);
        step();
        chk({tag, "_done_clr"}, inv_done, 0);
    endtask

    task automatic rand_cycle(input int n);
        ent_t x = rnd_ent();
        bit dwe = ($urandom_range(0, 3) == 0);
        bit dfl = ($urandom_range(0, 3) == 0);
        bit [1:0] req = 2'($urandom);
        bit [19:0] va [2];
        bit [9:0]  as [2];
        bit h [2]; int ix [2]; bit [5:0] ps [2]; bit [25:0] pt [2];
        int widx = $urandom_range(0, TLBNUM-1);
        for (int k = 0; k < 2; k++) begin
            va[k] = ($urandom_range(0, 3) != 0) ? va_of($urandom_range(0, TLBNUM-1)) : 20'($urandom);
            as[k] = 10'($urandom_range(1, 3));
            m_search(va[k], as[k], h[k], ix[k], ps[k], pt[k]);
        end
        drive_w(x);
        w_index = 4'(widx); we = dwe; fill = dfl;
        s_req = req; s_va = {va[1], va[0]}; s_asid = {as[1], as[0]};
        step();
        we = 0; fill = 0; s_req = 0;
        for (int k = 0; k < 2; k++) chk_port(k, h[k], ix[k], ps[k], pt[k], req[k], $sformatf("rnd%0d_%0d", n, k));
        if (dwe) m_tab[widx] = x;
        else if (dfl) begin
            m_tab[m_fill] = x;
            m_fill = (m_fill + 1) % TLBNUM;
        end
        chk($sformatf("rnd%0d_fill", n), fill_index, m_fill);
        r_index = 4'($urandom_range(0, TLBNUM-1));
        #1;
        chk($sformatf("rnd%0d_re", n), r_e, m_tab[r_index].e);
        if (m_tab[r_index].e) begin
            chk($sformatf("rnd%0d_rfields", n), {r_g, r_asid, r_vppn, r_ps},
                {m_tab[r_index].g, m_tab[r_index].asid, m_tab[r_index].vppn, m_tab[r_index].ps});
            chk($sformatf("rnd%0d_rpt", n), {r_phytran1, r_phytran0}, {m_tab[r_index].p1, m_tab[r_index].p0});
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 0; s_req = 0; s_va = 0; s_asid = 0; r_index = 0;
        we = 0; fill = 0; w_index = 0; w_e = 0; w_g = 0; w_asid = 0; w_vppn = 0; w_ps = 0;
        w_phytran0 = 0; w_phytran1 = 0; inv_req = 0; inv_op = 0; inv_asid = 0; inv_va = 0;
        m_reset();
        step();
        step();
        chk("rst_valid", s_valid, 0);
        chk("rst_hit", s_hit, 0);
        chk("rst_index", s_index, 0);
        chk("rst_ps", s_ps, 0);
        chk("rst_phytran", s_phytran, 0);
        chk("rst_inv", {inv_busy, inv_done, inv_bad_op}, 0);
        chk("rst_fill", fill_index, 0);
        chk("rst_re", r_e, 0);
        reset = 1;

        // 4 KB page, odd half selected by VA bit 0.
        wr(3, mk(1, 0, 10'd5, 19'h12345, 6'd12, 20'hAAAAA, 20'hBBBBB));
        srch2(20'h2468B, 10'd5, 20'h2468B, 10'd6, "asid");
        chk("t1_hit", s_hit, 2'b01);
        chk("t1_idx0", s_index[3:0], 3);
        chk("t1_ppn", s_phytran[25:6], 20'hBBBBB);
        chk("t1_idx1", s_index[7:4], 0);

        // Global 2 MB page; VA bit 9 of 0x3E5FF is clear so the even half is used.
        wr(7, mk(1, 1, 10'd9, 19'h1F200, 6'd21, 20'h11111, 20'h22222));
        srch2(20'h3E5FF, 10'd1, 20'h3E5FF, 10'd2, "big");
        chk("t2_hit", s_hit, 2'b11);
        chk("t2_idx", s_index, 8'h77);
        chk("t2_ps", s_ps, {6'd21, 6'd21});
        chk("t2_ppn", s_phytran[25:6], 20'h11111);

        // Duplicate entries resolve to the lowest index.
        wr(2, mk(1, 1, 10'd0, 19'h00ABC, 6'd12, 20'h00002, 20'h10002));
        wr(9, mk(1, 1, 10'd0, 19'h00ABC, 6'd12, 20'h00009, 20'h10009));
        srch2(20'h01578, 10'd4, 20'h01579, 10'd4, "dup");
        chk("t3_idx", s_index[3:0], 2);
        wr(2, mk(0, 1, 10'd0, 19'h00ABC, 6'd12, 20'h00002, 20'h10002));
        srch2(20'h01578, 10'd4, 20'h01579, 10'd4, "dup2");
        chk("t3_idx2", s_index[3:0], 9);

        // Fill pointer: advance, wrap, and yield to a simultaneous TLBWR.
        do_reset();
        for (int i = 0; i < 5; i++) do_fill(mk(1, 0, 10'd1, 19'h00200 + 19'(i), 6'd12, 20'(i), 20'(i)));
        chk("fill5", fill_index, 5);
        chk_all_e("fill5");
        for (int i = 5; i < 16; i++) do_fill(mk(1, 0, 10'd1, 19'h00200 + 19'(i), 6'd12, 20'(i), 20'(i)));
        chk("fill16", fill_index, 0);
        drive_w(mk(1, 1, 10'd7, 19'h00777, 6'd12, 20'h77777, 20'h77777));
        w_index = 4'd10; we = 1; fill = 1;
        step();
        we = 0; fill = 0;
        m_tab[10] = mk(1, 1, 10'd7, 19'h00777, 6'd12, 20'h77777, 20'h77777);
        chk("wefill_ptr", fill_index, 0);
        r_index = 4'd10;
        #1;
        chk("wefill_vppn", r_vppn, 19'h00777);
        r_index = 4'd0;
        #1;
        chk("wefill_e0", {r_e, r_vppn}, {1'b1, 19'h00200});

        // Sweep op 3 removes only non-global entries; bad op changes nothing.
        do_reset();
        for (int i = 0; i < 16; i++) do_fill(mk(1, i % 2 == 1, 10'd1, 19'h00100 + 19'(i), 6'd12, 20'(i), 20'(i + 16)));
        inv_run(3, 10'd0, 20'd0, "op3");
        for (int i = 0; i < 16; i++) begin
            srch2({19'h00100 + 19'(i), 1'b0}, 10'd1, {19'h00100 + 19'((i+1) % 16), 1'b1}, 10'd1, $sformatf("op3s%0d", i));
            chk($sformatf("op3_keep%0d", i), s_hit[0], i % 2);
        end
        inv_run(7, 10'd1, 20'd0, "op7");
        chk_all_e("op7");

        // A TLBWR landing on the group being cleared survives the sweep.
        for (int i = 0; i < 16; i++) wr(i, mk(1, 0, 10'd2, 19'h00300 + 19'(i), 6'd12, 20'(i), 20'(i)));
        inv_req = 1; inv_op = 3'd1;
        step();
        inv_req = 0;
        step();
        wr(5, mk(1, 0, 10'd2, 19'h00555, 6'd12, 20'h55555, 20'h55555));
        for (int i = 0; i < 16; i++) if (i != 5) m_tab[i].e = 0;
        step();
        step();
        chk("ww_done", inv_done, 1);
        chk_all_e("ww");

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 300; n++) rand_cycle(n);
        for (int t = 0; t < 8; t++) begin
            int op = $urandom_range(0, 7);
            for (int i = 0; i < 16; i++) wr(i, rnd_ent());
            inv_run(op, 10'($urandom_range(1, 3)), va_of($urandom_range(0, 15)), $sformatf("rinv%0d", t));
            chk_all_e($sformatf("rinv%0d", t));
        end

        // Reset during a sweep aborts without a done pulse.
        for (int i = 0; i < 8; i++) wr(i, mk(1, 0, 10'd3, 19'h00300 + 19'(i), 6'd12, 20'(i), 20'(i)));
        inv_req = 1; inv_op = 3'd5; inv_asid = 10'd3; inv_va = {19'h00303, 1'b0};
        step();
        inv_req = 0;
        chk("abort_busy1", inv_busy, 1);
        step();
        chk("abort_busy2", inv_busy, 1);
        reset = 0;
        step();
        reset = 1;
        m_reset();
        chk("abort_busy", inv_busy, 0);
        chk("abort_done", inv_done, 0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("abort_idle%0d", c), {inv_busy, inv_done}, 0);
        end
        for (int i = 0; i < 8; i += 2) begin
            srch2({19'h00300 + 19'(i), 1'b0}, 10'd3, {19'h00301 + 19'(i), 1'b0}, 10'd3, $sformatf("abort_s%0d", i));
            chk($sformatf("abort_miss%0d", i), s_hit, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
